random_normal_clt: RTL and testbench
====================================

RANDOM_NORMAL_CLT -- requirements
Module: random_normal_clt

Interface
REQ-001 Parameter IN_WIDTH, default 16: width of signed two's-complement uniform input sample.
REQ-002 Parameter LOG2_N, default 2: number of summed samples is N = 2^LOG2_N, legal range 1..6.
REQ-003 Parameter OUT_WIDTH, default IN_WIDTH+LOG2_N: output width; value fixed by the formula, no other value legal.
REQ-004 Parameter CLIP_LEVEL, default 2^(IN_WIDTH-1): positive clip magnitude; used only under RANDOM_NORMAL_CLIP_EN.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 uniform_in  input  IN_WIDTH  signed uniform sample, e.g. random_uniform.random.
REQ-008 uniform_valid  input  1  uniform_in valid this cycle.
REQ-009 uniform_ready  output  1  block accepts uniform_in this cycle.
REQ-010 normal_out  output  OUT_WIDTH  signed approximately Gaussian sample.
REQ-011 normal_valid  output  1  normal_out valid.
REQ-012 normal_ready  input  1  consumer accepts normal_out.
REQ-013 clip_count  output  16  saturating count of clipped results.

Function
REQ-014 Input transfer SHALL occur on a rising edge with uniform_valid && uniform_ready; output transfer on normal_valid && normal_ready.
REQ-015 Accumulator (OUT_WIDTH bits) SHALL add the sign-extended uniform_in on each input transfer; sample counter (LOG2_N bits) SHALL increment on each input transfer.
REQ-016 On the transfer of the N-th sample (counter == N-1), acc + uniform_in SHALL load the output register, accumulator and counter SHALL clear in the same cycle, and normal_valid SHALL rise the next cycle (latency 1 from final sample).
REQ-017 Sum SHALL be exact; OUT_WIDTH guarantees no overflow (range -N*2^(IN_WIDTH-1) .. N*(2^(IN_WIDTH-1)-1)).
REQ-018 FSM states: ACCUM (counter < N-1), LAST (counter == N-1), BLOCKED (LAST with normal_valid && !normal_ready).
REQ-019 uniform_ready SHALL be 1 in ACCUM and LAST; 0 only in BLOCKED, i.e. uniform_ready = !(counter==N-1 && normal_valid && !normal_ready).
REQ-020 Simultaneous completion and output transfer (normal_valid && normal_ready and N-th sample accepted) SHALL replace normal_out with the new sum and keep normal_valid at 1, with no bubble.
REQ-021 normal_valid SHALL fall after an output transfer with no new result; normal_out SHALL hold its value while normal_valid && !normal_ready.
REQ-022 Counter SHALL wrap from N-1 to 0; no samples SHALL be lost or duplicated under any backpressure pattern.
REQ-023 uniform_valid low SHALL leave accumulator and counter unchanged.

Reset
REQ-024 Reset asserted SHALL immediately clear accumulator, counter, normal_out, normal_valid and clip_count to 0 and enter ACCUM.
REQ-025 uniform_ready SHALL read 1 while reset is asserted and after release; partial sums SHALL be discarded on reset mid-accumulation.

Configuration
REQ-026 With RANDOM_NORMAL_CLIP_EN defined, the completed sum SHALL saturate to ±CLIP_LEVEL before loading normal_out, and clip_count SHALL increment (saturating at 16'hFFFF) on each clipped result.
REQ-027 Without RANDOM_NORMAL_CLIP_EN, no clipping logic SHALL exist, normal_out SHALL equal the raw sum, and clip_count SHALL be constant 0.

Verification (IN_WIDTH=16, LOG2_N=2)
REQ-028 Assert reset mid-run -> normal_out=0, normal_valid=0, clip_count=0, uniform_ready=1 asynchronously.
REQ-029 normal_ready=1, feed 100, -50, 7, 1 back-to-back -> normal_out=58 with normal_valid high exactly one cycle after 4th transfer.
REQ-030 Feed 4x -32768 then 4x 32767 -> normal_out=-131072 (18'h20000) then 131068.
REQ-031 normal_ready=0, present 8 samples continuously -> first result held, uniform_ready=0 while 8th presented; raise normal_ready -> first result taken, 8th sample accepted same cycle, second result valid next cycle.
REQ-032 Accept 2 samples, pulse reset, then feed 1,2,3,4 -> normal_out=10.
REQ-033 RANDOM_NORMAL_CLIP_EN, CLIP_LEVEL=1000, feed 4x 500 then 4x -500 -> normal_out=1000 then -1000, clip_count=2.

Source files
------------

// File: rtl/random_normal_clt.sv
// Central-limit Gaussian approximator: sums N = 2^LOG2_N signed uniform samples into one output.
// Define RANDOM_NORMAL_CLIP_EN to saturate each sum to +/-CLIP_LEVEL and count the clipped results.
module random_normal_clt #(
  parameter int IN_WIDTH   = 16,
  parameter int LOG2_N     = 2,
  parameter int OUT_WIDTH  = IN_WIDTH + LOG2_N,
  parameter int CLIP_LEVEL = 2 ** (IN_WIDTH - 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_WIDTH-1:0]  uniform_in,
  input  logic                        uniform_valid,
  output logic                        uniform_ready,
  output logic signed [OUT_WIDTH-1:0] normal_out,
  output logic                        normal_valid,
  input  logic                        normal_ready,
  output logic [15:0]                 clip_count
);

  if (OUT_WIDTH != IN_WIDTH + LOG2_N || LOG2_N < 1 || LOG2_N > 6 || CLIP_LEVEL < 1) begin : g_param_check
    $error("random_normal_clt: illegal parameter combination");
  end

  typedef enum logic [1:0] {ACCUM, LAST, BLOCKED} state_e;

  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  state_e                        state_q, state_d, fsm_state;
  logic [LOG2_N-1:0]             cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]   out_q, out_d;
  logic                          valid_q, valid_d;
  logic signed [OUT_WIDTH-1:0]   sum;
  logic signed [OUT_WIDTH-1:0]   result;
  logic                          in_xfer, out_xfer, complete;

  // BLOCKED is the LAST state seen while the held result cannot leave.
  always_comb begin
    fsm_state = state_q;
    if (state_q == LAST && valid_q && !normal_ready) begin
      fsm_state = BLOCKED;
    end
  end

  assign uniform_ready = (fsm_state != BLOCKED);
  assign in_xfer       = uniform_valid && uniform_ready;
  assign out_xfer      = valid_q && normal_ready;
  assign complete      = in_xfer && (state_q == LAST);
  assign sum           = acc_q + OUT_WIDTH'(uniform_in);

`ifdef RANDOM_NORMAL_CLIP_EN
  localparam logic signed [OUT_WIDTH-1:0] CLIP_POS = OUT_WIDTH'(CLIP_LEVEL);
  localparam logic signed [OUT_WIDTH-1:0] CLIP_NEG = -CLIP_POS;

  logic        clipped;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    result  = sum;
    clipped = 1'b0;
    if (sum > CLIP_POS) begin
      result  = CLIP_POS;
      clipped = 1'b1;
    end else if (sum < CLIP_NEG) begin
      result  = CLIP_NEG;
      clipped = 1'b1;
    end
  end

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (complete && clipped && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`else
  assign result     = sum;
  assign clip_count = '0;
`endif

  // A completing sample may coincide with the consumer taking the previous result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q;
    if (out_xfer) begin
      valid_d = 1'b0;
    end
    if (in_xfer) begin
      if (state_q == LAST) begin
        acc_d   = '0;
        cnt_d   = '0;
        out_d   = result;
        valid_d = 1'b1;
        state_d = ACCUM;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + LOG2_N'(1);
        state_d = (cnt_d == LAST_IDX) ? LAST : ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign normal_out   = out_q;
  assign normal_valid = valid_q;

endmodule

// File: tb/tb_random_normal_clt.sv
// Directed self-checking bench for random_normal_clt with IN_WIDTH=16, LOG2_N=2.
// Clip expectations follow RANDOM_NORMAL_CLIP_EN when the bench is built with it.
module tb_random_normal_clt;

`ifdef RANDOM_NORMAL_CLIP_EN
  localparam int  CLIP_LVL   = 1000;
  localparam longint POS_EXP = 1000;
  localparam longint NEG_EXP = -1000;
  localparam longint CLIP_N1 = 1;
  localparam longint CLIP_N2 = 2;
`else
  localparam int  CLIP_LVL   = 32768;
  localparam longint POS_EXP = 2000;
  localparam longint NEG_EXP = -2000;
  localparam longint CLIP_N1 = 0;
  localparam longint CLIP_N2 = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] uniform_in;
  logic               uniform_valid;
  logic               uniform_ready;
  logic signed [17:0] normal_out;
  logic               normal_valid;
  logic               normal_ready;
  logic [15:0]        clip_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  random_normal_clt #(
    .IN_WIDTH  (16),
    .LOG2_N    (2),
    .OUT_WIDTH (18),
    .CLIP_LEVEL(CLIP_LVL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uniform_in   (uniform_in),
    .uniform_valid(uniform_valid),
    .uniform_ready(uniform_ready),
    .normal_out   (normal_out),
    .normal_valid (normal_valid),
    .normal_ready (normal_ready),
    .clip_count   (clip_count)
  );

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input, then land 1ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic signed [15:0] d);
    uniform_valid = v;
    uniform_in    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    uniform_valid = 1'b0;
    uniform_in    = '0;
    normal_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", normal_out, 0);
    checkOutput("reset_valid", normal_valid, 0);
    checkOutput("reset_clip", clip_count, 0);
    checkOutput("reset_ready", uniform_ready, 1);
    reset = 1'b0;

    // 100 - 50 + 7 + 1 = 58, valid on the edge of the fourth transfer
    applyStimulus(1, 100);
    applyStimulus(1, -50);
    applyStimulus(1, 7);
    checkOutput("basic_not_yet_valid", normal_valid, 0);
    applyStimulus(1, 1);
    checkOutput("basic_sum", normal_out, 58);
    checkOutput("basic_valid", normal_valid, 1);
    applyStimulus(0, 0);
    checkOutput("basic_valid_drop", normal_valid, 0);

    // extremes of the input range
    repeat (4) applyStimulus(1, -32768);
    checkOutput("min_sum", normal_out, -131072);
    checkOutput("min_valid", normal_valid, 1);
    applyStimulus(1, 32767);
    checkOutput("min_consumed", normal_valid, 0);
    repeat (3) applyStimulus(1, 32767);
    checkOutput("max_sum", normal_out, 131068);
    checkOutput("max_valid", normal_valid, 1);
    applyStimulus(0, 0);

    // backpressure: eight samples presented continuously while the consumer stalls
    normal_ready = 1'b0;
    for (int i = 1; i <= 7; i++) applyStimulus(1, 16'(i));
    checkOutput("bp_first_sum", normal_out, 10);
    checkOutput("bp_first_valid", normal_valid, 1);
    uniform_valid = 1'b1;
    uniform_in    = 16'sd8;
    #1;
    checkOutput("bp_ready_low", uniform_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("bp_held_out", normal_out, 10);
    checkOutput("bp_held_valid", normal_valid, 1);
    checkOutput("bp_still_blocked", uniform_ready, 0);
    normal_ready = 1'b1;
    #1;
    checkOutput("bp_ready_release", uniform_ready, 1);
    @(posedge clk);
    #1;
    uniform_valid = 1'b0;
    checkOutput("bp_second_sum", normal_out, 26);
    checkOutput("bp_second_valid", normal_valid, 1);
    @(posedge clk);
    #1;
    checkOutput("bp_second_taken", normal_valid, 0);

    // reset mid-accumulation with a result still pending
    normal_ready = 1'b0;
    repeat (4) applyStimulus(1, 1);
    checkOutput("pre_reset_valid", normal_valid, 1);
    applyStimulus(1, 100);
    applyStimulus(1, 200);
    uniform_valid = 1'b0;
    reset = 1'b1;
    #2;
    checkOutput("async_reset_out", normal_out, 0);
    checkOutput("async_reset_valid", normal_valid, 0);
    checkOutput("async_reset_clip", clip_count, 0);
    checkOutput("async_reset_ready", uniform_ready, 1);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    normal_ready = 1'b1;
    applyStimulus(1, 1);
    applyStimulus(1, 2);
    applyStimulus(1, 3);
    applyStimulus(1, 4);
    checkOutput("post_reset_sum", normal_out, 10);
    checkOutput("post_reset_valid", normal_valid, 1);

    // saturation behaviour (raw sums when clipping is not built in)
    repeat (4) applyStimulus(1, 500);
    checkOutput("clip_pos_out", normal_out, POS_EXP);
    checkOutput("clip_pos_count", clip_count, CLIP_N1);
    repeat (4) applyStimulus(1, -500);
    checkOutput("clip_neg_out", normal_out, NEG_EXP);
    checkOutput("clip_neg_count", clip_count, CLIP_N2);
    applyStimulus(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
